// File: rtl/spi_byte_sequencer.sv
// spi_byte_sequencer: host-side byte front end for spi_master.
// The host queues bytes in a TX FIFO and pulses start. The whole queue is then sent
// as one burst, one byte per tx_ready/TX_DV handshake. Every byte returned by
// spi_master is collected in an RX FIFO for the host to drain. A watchdog aborts the
// burst if an expected rx_dv never arrives.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | waiting for start; burst length latched from tx_count
//   LOAD    | TX head copied to m_tx_byte and popped
//   ISSUE   | waiting for m_tx_ready; TX_DV raised on the handshake
//   WAIT_RX | watchdog running; waiting for m_rx_dv to capture the reply
//   DONE    | burst finished (normal or abort); done pulses on the way to IDLE
module spi_byte_sequencer #(
   parameter int DEPTH   = 8,
   parameter int AW      = 3,
   parameter int TIMEOUT = 1024
) (
   input  logic          i_clk,
   input  logic          reset,
   input  logic          wr_en,
   input  logic [7:0]    wr_data,
   output logic          tx_full,
   output logic [AW:0]   tx_count,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic          timeout_err,
   input  logic          rx_rd_en,
   output logic [7:0]    rx_data,
   output logic          rx_empty,
   output logic          rx_overflow,
   output logic [7:0]    m_tx_byte,
   output logic          m_tx_dv,
   input  logic          m_tx_ready,
   input  logic          m_rx_dv,
   input  logic [7:0]    m_rx_byte
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ISSUE,
      S_WAIT_RX,
      S_DONE
   } state_t;

   localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE   = AW'(1);
   // Watchdog counts down; reaching zero is the same cycle an up-counter would hit TIMEOUT-1.
   localparam logic [15:0]   WDOG_LOAD = 16'(TIMEOUT - 1);

   state_t        state;
   logic [AW:0]   remaining;
   logic [15:0]   wdog_cnt;

   logic [7:0]    tx_mem [DEPTH];
   logic [AW-1:0] tx_wptr;
   logic [AW-1:0] tx_rptr;
   logic [AW:0]   tx_cnt;
   logic          tx_push;
   logic          tx_pop;

   logic [7:0]    rx_mem [DEPTH];
   logic [AW-1:0] rx_wptr;
   logic [AW-1:0] rx_rptr;
   logic [AW:0]   rx_cnt;
   logic          rx_full;
   logic          rx_push;
   logic          rx_pop;
   logic          rx_write;

   assign tx_full  = (tx_cnt == CNT_FULL);
   assign tx_count = tx_cnt;
   assign tx_push  = wr_en && !tx_full;
   assign tx_pop   = (state == S_LOAD) && (tx_cnt != '0);

   assign rx_full  = (rx_cnt == CNT_FULL);
   assign rx_empty = (rx_cnt == '0);
   assign rx_data  = rx_mem[rx_rptr];
   assign rx_push  = (state == S_WAIT_RX) && m_rx_dv;
   assign rx_pop   = rx_rd_en && !rx_empty;
   // A full RX FIFO still accepts a byte when the host pops in the same cycle.
   assign rx_write = rx_push && (!rx_full || rx_pop);

   // TX FIFO storage; contents are only meaningful between the pointers.
   always_ff @(posedge i_clk) begin
      if (tx_push)
         tx_mem[tx_wptr] <= wr_data;
   end

   // TX FIFO pointers and occupancy.
   always_ff @(posedge i_clk or posedge reset) begin
      if (reset) begin
         tx_wptr <= '0;
         tx_rptr <= '0;
         tx_cnt  <= '0;
      end else begin
         if (tx_push)
            tx_wptr <= tx_wptr + PTR_ONE;
         if (tx_pop)
            tx_rptr <= tx_rptr + PTR_ONE;
         case ({tx_push, tx_pop})
            2'b10:   tx_cnt <= tx_cnt + CNT_ONE;
            2'b01:   tx_cnt <= tx_cnt - CNT_ONE;
            default: tx_cnt <= tx_cnt;
         endcase
      end
   end

   // RX FIFO storage.
   always_ff @(posedge i_clk) begin
      if (rx_write)
         rx_mem[rx_wptr] <= m_rx_byte;
   end

   // RX FIFO pointers, occupancy and sticky overflow flag.
   always_ff @(posedge i_clk or posedge reset) begin
      if (reset) begin
         rx_wptr     <= '0;
         rx_rptr     <= '0;
         rx_cnt      <= '0;
         rx_overflow <= 1'b0;
      end else begin
         if (rx_write)
            rx_wptr <= rx_wptr + PTR_ONE;
         if (rx_pop)
            rx_rptr <= rx_rptr + PTR_ONE;
         if (rx_push && !rx_write)
            rx_overflow <= 1'b1;
         case ({rx_write, rx_pop})
            2'b10:   rx_cnt <= rx_cnt + CNT_ONE;
            2'b01:   rx_cnt <= rx_cnt - CNT_ONE;
            default: rx_cnt <= rx_cnt;
         endcase
      end
   end

   // Burst sequencer with registered handshake and status outputs.
   always_ff @(posedge i_clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         remaining   <= '0;
         wdog_cnt    <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         m_tx_dv     <= 1'b0;
         m_tx_byte   <= 8'h00;
         timeout_err <= 1'b0;
      end else begin
         done    <= 1'b0;
         m_tx_dv <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  remaining   <= tx_cnt;
                  timeout_err <= 1'b0;
                  busy        <= 1'b1;
                  state       <= (tx_cnt == '0) ? S_DONE : S_LOAD;
               end
            end
            S_LOAD: begin
               m_tx_byte <= tx_mem[tx_rptr];
               state     <= S_ISSUE;
            end
            S_ISSUE: begin
               if (m_tx_ready) begin
                  m_tx_dv  <= 1'b1;
                  wdog_cnt <= WDOG_LOAD;
                  state    <= S_WAIT_RX;
               end
            end
            S_WAIT_RX: begin
               if (m_rx_dv) begin
                  remaining <= remaining - CNT_ONE;
                  wdog_cnt  <= WDOG_LOAD;
                  state     <= (remaining == CNT_ONE) ? S_DONE : S_LOAD;
               end else if (wdog_cnt == '0) begin
                  timeout_err <= 1'b1;
                  state       <= S_DONE;
               end else begin
                  wdog_cnt <= wdog_cnt - 16'd1;
               end
            end
            S_DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
